// File: rtl/risk_pkg.sv
// Shared types and constants for the kill-switch control plane.
package risk_pkg;

    localparam int KS_KEY_W   = 16;
    localparam int KS_TIMER_W = 32;

    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        ARMED       = 3'd1,
        TRIPPED     = 3'd2,
        LOCKED      = 3'd3,
        CONFIRM     = 3'd4,
        RESET_ISSUE = 3'd5,
        WAIT_CLEAR  = 3'd6
    } ks_seq_state_e;

    // True when a running phase timer is on its final cycle (or already idle).
    function automatic logic timer_final(input logic [KS_TIMER_W-1:0] value, input logic expired);
        return expired || (value == 32'd1);
    endfunction

endpackage

// File: rtl/ks_timer.sv
// Loadable 32-bit down-counter shared by the cooldown, confirm-window and
// ack-timeout phases; only one of those phases is ever active at a time.
module ks_timer
    import risk_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [KS_TIMER_W-1:0] load_value,
    input  logic                  dec,
    output logic [KS_TIMER_W-1:0] value,
    output logic                  expired
);

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= 32'd0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && (value != 32'd0)) begin
            value <= value - 32'd1;
        end else begin
            value <= value;
        end
    end

    assign expired = (value == 32'd0);

endmodule

// File: rtl/kill_switch_sequencer.sv
// Kill-switch sequencer: merges trip sources into one trigger, enforces a
// post-trip cooldown, then a keyed two-phase reset with clear verification.
module kill_switch_sequencer
    import risk_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int SRC_W           = $clog2(NUM_SRC),
    parameter int COOLDOWN_CYCLES = 1024,
    parameter int CONFIRM_WINDOW  = 64,
    parameter int ACK_TIMEOUT     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_arm,
    input  logic [KS_KEY_W-1:0] cfg_reset_key,
    input  logic [NUM_SRC-1:0]  trig_src,
    input  logic                reset_req,
    input  logic                reset_confirm,
    input  logic [KS_KEY_W-1:0] reset_key,
    input  logic                ks_killed,
    output logic                ks_armed,
    output logic                ks_trigger,
    output logic                ks_reset,
    output logic [2:0]          state,
    output logic [SRC_W-1:0]    trip_source,
    output logic [NUM_SRC-1:0]  trip_mask,
    output logic [31:0]         trip_count,
    output logic                reset_rejected,
    output logic                err_ack_timeout
);

    ks_seq_state_e         state_r;
    ks_seq_state_e         next_state_s;
    logic                  timer_load_s;
    logic [KS_TIMER_W-1:0] timer_load_value_s;
    logic                  timer_dec_s;
    logic [KS_TIMER_W-1:0] timer_value_s;
    logic                  timer_expired_s;
    logic                  timer_last_s;
    logic                  any_trig_s;
    logic                  post_trip_s;
    logic [SRC_W-1:0]      first_idx_s;
    logic                  trigger_s;
    logic                  reset_pulse_s;
    logic                  reject_s;
    logic                  ack_err_s;
    logic                  first_trip_s;
    logic                  record_trip_s;
    logic                  clear_trip_s;

    ks_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load_s),
        .load_value (timer_load_value_s),
        .dec        (timer_dec_s),
        .value      (timer_value_s),
        .expired    (timer_expired_s)
    );

    assign any_trig_s   = |trig_src;
    assign timer_last_s = timer_final(timer_value_s, timer_expired_s);
    assign post_trip_s  = (state_r != DISARMED) && (state_r != ARMED);
    assign state        = state_r;

    // Priority encoder: lowest set trip source index wins.
    always_comb begin
        first_idx_s = {SRC_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (trig_src[i]) begin
                first_idx_s = SRC_W'(i);
            end else begin
                first_idx_s = first_idx_s;
            end
        end
    end

    // Next-state and action decode; a trip in any post-trip state beats everything else.
    always_comb begin
        next_state_s       = state_r;
        timer_load_s       = 1'b0;
        timer_load_value_s = 32'd0;
        timer_dec_s        = 1'b0;
        trigger_s          = 1'b0;
        reset_pulse_s      = 1'b0;
        reject_s           = 1'b0;
        ack_err_s          = 1'b0;
        first_trip_s       = 1'b0;
        record_trip_s      = 1'b0;
        clear_trip_s       = 1'b0;
        if (post_trip_s && any_trig_s) begin
            // The kill switch may already have been cleared once a reset was issued.
            next_state_s       = TRIPPED;
            record_trip_s      = 1'b1;
            timer_load_s       = 1'b1;
            timer_load_value_s = 32'(COOLDOWN_CYCLES);
            trigger_s          = (state_r == RESET_ISSUE) || (state_r == WAIT_CLEAR);
        end else begin
            case (state_r)
                DISARMED: begin
                    if (cfg_arm) begin
                        next_state_s = ARMED;
                    end else begin
                        next_state_s = DISARMED;
                    end
                end
                ARMED: begin
                    if (any_trig_s) begin
                        next_state_s       = TRIPPED;
                        trigger_s          = 1'b1;
                        first_trip_s       = 1'b1;
                        record_trip_s      = 1'b1;
                        timer_load_s       = 1'b1;
                        timer_load_value_s = 32'(COOLDOWN_CYCLES);
                    end else if (!cfg_arm) begin
                        next_state_s = DISARMED;
                    end else begin
                        next_state_s = ARMED;
                    end
                end
                TRIPPED: begin
                    timer_dec_s = 1'b1;
                    reject_s    = reset_req;
                    if (timer_last_s) begin
                        next_state_s = LOCKED;
                    end else begin
                        next_state_s = TRIPPED;
                    end
                end
                LOCKED: begin
                    if (reset_req) begin
                        next_state_s       = CONFIRM;
                        timer_load_s       = 1'b1;
                        timer_load_value_s = 32'(CONFIRM_WINDOW);
                    end else begin
                        next_state_s = LOCKED;
                    end
                end
                CONFIRM: begin
                    timer_dec_s = 1'b1;
                    if (reset_confirm && (reset_key == cfg_reset_key)) begin
                        next_state_s  = RESET_ISSUE;
                        reset_pulse_s = 1'b1;
                    end else if (reset_confirm || timer_last_s) begin
                        next_state_s = LOCKED;
                        reject_s     = 1'b1;
                    end else begin
                        next_state_s = CONFIRM;
                    end
                end
                RESET_ISSUE: begin
                    next_state_s       = WAIT_CLEAR;
                    timer_load_s       = 1'b1;
                    timer_load_value_s = 32'(ACK_TIMEOUT);
                end
                WAIT_CLEAR: begin
                    if (!ks_killed) begin
                        next_state_s       = cfg_arm ? ARMED : DISARMED;
                        clear_trip_s       = 1'b1;
                        timer_load_s       = 1'b1;
                        timer_load_value_s = 32'd0;
                    end else if (timer_last_s) begin
                        next_state_s = LOCKED;
                        ack_err_s    = 1'b1;
                    end else begin
                        next_state_s = WAIT_CLEAR;
                        timer_dec_s  = 1'b1;
                    end
                end
                default: begin
                    next_state_s = DISARMED;
                end
            endcase
        end
    end

    // State register, registered pulses and sticky trip bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= DISARMED;
            ks_armed        <= 1'b0;
            ks_trigger      <= 1'b0;
            ks_reset        <= 1'b0;
            reset_rejected  <= 1'b0;
            err_ack_timeout <= 1'b0;
            trip_source     <= {SRC_W{1'b0}};
            trip_mask       <= {NUM_SRC{1'b0}};
            trip_count      <= 32'd0;
        end else begin
            state_r         <= next_state_s;
            ks_armed        <= (next_state_s != DISARMED);
            ks_trigger      <= trigger_s;
            ks_reset        <= reset_pulse_s;
            reset_rejected  <= reject_s;
            err_ack_timeout <= ack_err_s;
            if (first_trip_s) begin
                trip_source <= first_idx_s;
            end else if (clear_trip_s) begin
                trip_source <= {SRC_W{1'b0}};
            end else begin
                trip_source <= trip_source;
            end
            if (clear_trip_s) begin
                trip_mask <= {NUM_SRC{1'b0}};
            end else if (record_trip_s) begin
                trip_mask <= trip_mask | trig_src;
            end else begin
                trip_mask <= trip_mask;
            end
            if (first_trip_s) begin
                trip_count <= trip_count + 32'd1;
            end else begin
                trip_count <= trip_count;
            end
        end
    end

endmodule

// File: tb/tb_kill_switch_sequencer.sv
// Bench for kill_switch_sequencer: table vectors, directed corner sequences
// and randomized traffic against a cycle-count based behavioural model.
module tb_kill_switch_sequencer;

    localparam int COOL = 8;
    localparam int WIN  = 64;
    localparam int ACK  = 16;

    localparam int S_DIS  = 0;
    localparam int S_ARM  = 1;
    localparam int S_TRIP = 2;
    localparam int S_LOCK = 3;
    localparam int S_CONF = 4;
    localparam int S_RI   = 5;
    localparam int S_WC   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_arm;
    logic [15:0] cfg_reset_key;
    logic [3:0]  trig_src;
    logic        reset_req;
    logic        reset_confirm;
    logic [15:0] reset_key;
    logic        ks_killed;
    logic        ks_armed;
    logic        ks_trigger;
    logic        ks_reset;
    logic [2:0]  state;
    logic [1:0]  trip_source;
    logic [3:0]  trip_mask;
    logic [31:0] trip_count;
    logic        reset_rejected;
    logic        err_ack_timeout;

    always #5 clk = ~clk;

    kill_switch_sequencer #(
        .NUM_SRC         (4),
        .SRC_W           (2),
        .COOLDOWN_CYCLES (COOL),
        .CONFIRM_WINDOW  (WIN),
        .ACK_TIMEOUT     (ACK)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_arm         (cfg_arm),
        .cfg_reset_key   (cfg_reset_key),
        .trig_src        (trig_src),
        .reset_req       (reset_req),
        .reset_confirm   (reset_confirm),
        .reset_key       (reset_key),
        .ks_killed       (ks_killed),
        .ks_armed        (ks_armed),
        .ks_trigger      (ks_trigger),
        .ks_reset        (ks_reset),
        .state           (state),
        .trip_source     (trip_source),
        .trip_mask       (trip_mask),
        .trip_count      (trip_count),
        .reset_rejected  (reset_rejected),
        .err_ack_timeout (err_ack_timeout)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase progress is kept as cycles elapsed in the phase.
    int        m_state;
    int        m_elapsed;
    int        m_src;
    bit [3:0]  m_mask;
    bit [31:0] m_count;
    bit        m_armed, m_trig, m_reset, m_rej, m_err;
    bit        stuck;

    typedef struct {
        bit       rst;
        bit       arm;
        bit [3:0] trig;
        int       st;
        bit       armed;
        bit       trg;
        int       src;
        bit [3:0] mask;
        int       cnt;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_step();
        bit any;
        any = (trig_src != 4'd0);
        m_trig = 1'b0; m_reset = 1'b0; m_rej = 1'b0; m_err = 1'b0;
        if (rst) begin
            m_state = S_DIS; m_elapsed = 0; m_src = 0; m_mask = 4'd0; m_count = 32'd0;
        end else if (m_state == S_DIS) begin
            if (cfg_arm) m_state = S_ARM;
        end else if (m_state == S_ARM) begin
            if (any) begin
                m_trig = 1'b1; m_src = lowest(trig_src); m_mask |= trig_src;
                m_count = m_count + 32'd1; m_state = S_TRIP; m_elapsed = 0;
            end else if (!cfg_arm) begin
                m_state = S_DIS;
            end
        end else if (any) begin
            if (m_state == S_RI || m_state == S_WC) m_trig = 1'b1;
            m_mask |= trig_src; m_state = S_TRIP; m_elapsed = 0;
        end else begin
            case (m_state)
                S_TRIP: begin
                    m_elapsed++;
                    if (reset_req) m_rej = 1'b1;
                    if (m_elapsed >= COOL) m_state = S_LOCK;
                end
                S_LOCK: if (reset_req) begin m_state = S_CONF; m_elapsed = 0; end
                S_CONF: begin
                    m_elapsed++;
                    if (reset_confirm) begin
                        if (reset_key == cfg_reset_key) begin m_state = S_RI; m_reset = 1'b1; end
                        else begin m_rej = 1'b1; m_state = S_LOCK; end
                    end else if (m_elapsed >= WIN) begin
                        m_rej = 1'b1; m_state = S_LOCK;
                    end
                end
                S_RI: begin m_state = S_WC; m_elapsed = 0; end
                S_WC: begin
                    m_elapsed++;
                    if (!ks_killed) begin
                        m_state = cfg_arm ? S_ARM : S_DIS; m_mask = 4'd0; m_src = 0;
                    end else if (m_elapsed >= ACK) begin
                        m_err = 1'b1; m_state = S_LOCK;
                    end
                end
                default: m_state = S_DIS;
            endcase
        end
        m_armed = (m_state != S_DIS);
    endtask

    // One clock: model follows the edge, outputs compared just after it,
    // then the kill-switch stand-in reacts to the expected pulses.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("state", state, m_state);
        check("ks_armed", ks_armed, m_armed);
        check("ks_trigger", ks_trigger, m_trig);
        check("ks_reset", ks_reset, m_reset);
        check("trip_source", trip_source, m_src);
        check("trip_mask", trip_mask, m_mask);
        check("trip_count", trip_count, m_count);
        check("reset_rejected", reset_rejected, m_rej);
        check("err_ack_timeout", err_ack_timeout, m_err);
        @(negedge clk);
        if (m_trig) ks_killed = 1'b1;
        else if (m_reset && !stuck) ks_killed = 1'b0;
        else ks_killed = ks_killed;
    endtask

    initial begin
        rst = 1'b1; cfg_arm = 1'b0; cfg_reset_key = 16'hBEEF; trig_src = 4'd0;
        reset_req = 1'b0; reset_confirm = 1'b0; reset_key = 16'd0; ks_killed = 1'b0; stuck = 1'b0;
        m_state = S_DIS; m_elapsed = 0; m_src = 0; m_mask = 4'd0; m_count = 32'd0;
        m_armed = 1'b0; m_trig = 1'b0; m_reset = 1'b0; m_rej = 1'b0; m_err = 1'b0;

        //          rst   arm   trig     st     armed trg   src mask     cnt
        tbl[0] = '{1'b1, 1'b0, 4'b0000, S_DIS,  1'b0, 1'b0, 0, 4'b0000, 0};
        tbl[1] = '{1'b0, 1'b0, 4'b0001, S_DIS,  1'b0, 1'b0, 0, 4'b0000, 0};
        tbl[2] = '{1'b0, 1'b1, 4'b0000, S_ARM,  1'b1, 1'b0, 0, 4'b0000, 0};
        tbl[3] = '{1'b0, 1'b1, 4'b0110, S_TRIP, 1'b1, 1'b1, 1, 4'b0110, 1};
        tbl[4] = '{1'b0, 1'b1, 4'b0000, S_TRIP, 1'b1, 1'b0, 1, 4'b0110, 1};
        tbl[5] = '{1'b0, 1'b0, 4'b1000, S_TRIP, 1'b1, 1'b0, 1, 4'b1110, 1};

        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rst = tbl[i].rst; cfg_arm = tbl[i].arm; trig_src = tbl[i].trig;
            tick();
            check("tbl_state", state, tbl[i].st);
            check("tbl_armed", ks_armed, tbl[i].armed);
            check("tbl_trigger", ks_trigger, tbl[i].trg);
            check("tbl_source", trip_source, tbl[i].src);
            check("tbl_mask", trip_mask, tbl[i].mask);
            check("tbl_count", trip_count, tbl[i].cnt);
        end
        trig_src = 4'd0; cfg_arm = 1'b1;

        // Early reset request rejected during cooldown, accepted once locked.
        repeat (4) tick();
        reset_req = 1'b1; tick(); reset_req = 1'b0;
        check("early_req_rejected", reset_rejected, 1);
        check("early_req_state", state, S_TRIP);
        repeat (3) tick();
        reset_req = 1'b1; tick(); reset_req = 1'b0;
        check("req_after_cooldown", state, S_CONF);

        // Good key: one reset pulse, kill switch clears, back to ARMED.
        reset_confirm = 1'b1; reset_key = 16'hBEEF; tick(); reset_confirm = 1'b0;
        check("good_key_reset", ks_reset, 1);
        tick();
        check("wait_clear_entry", state, S_WC);
        check("reset_single_pulse", ks_reset, 0);
        tick();
        check("cleared_state", state, S_ARM);
        check("cleared_mask", trip_mask, 0);

        // Wrong key, then confirm-window expiry.
        trig_src = 4'b0100; tick(); trig_src = 4'd0;
        check("second_trip_count", trip_count, 2);
        repeat (COOL) tick();
        check("locked_after_cool", state, S_LOCK);
        reset_req = 1'b1; tick(); reset_req = 1'b0;
        reset_confirm = 1'b1; reset_key = 16'h1234; tick(); reset_confirm = 1'b0;
        check("bad_key_rejected", reset_rejected, 1);
        check("bad_key_state", state, S_LOCK);
        reset_req = 1'b1; tick(); reset_req = 1'b0;
        repeat (WIN - 1) tick();
        check("window_not_yet", state, S_CONF);
        tick();
        check("window_expired_rej", reset_rejected, 1);
        check("window_expired_state", state, S_LOCK);

        // Kill switch never clears: ack timeout, trip info kept.
        stuck = 1'b1;
        reset_req = 1'b1; tick(); reset_req = 1'b0;
        reset_confirm = 1'b1; reset_key = 16'hBEEF; tick(); reset_confirm = 1'b0;
        tick();
        repeat (ACK - 1) tick();
        check("ack_not_yet", state, S_WC);
        tick();
        check("ack_timeout_err", err_ack_timeout, 1);
        check("ack_timeout_state", state, S_LOCK);
        check("ack_timeout_src", trip_source, 2);
        stuck = 1'b0;

        // Trip beats a valid confirm; cooldown restarts; no disarm while tripped.
        reset_req = 1'b1; tick(); reset_req = 1'b0;
        reset_confirm = 1'b1; reset_key = 16'hBEEF; trig_src = 4'b1000; tick();
        reset_confirm = 1'b0; trig_src = 4'd0;
        check("trip_beats_confirm", state, S_TRIP);
        check("no_reset_on_trip", ks_reset, 0);
        check("trip_mask_merge", trip_mask, 4'b1100);
        cfg_arm = 1'b0; tick();
        check("armed_forced", ks_armed, 1);
        repeat (COOL - 2) tick();
        check("cooldown_restarted", state, S_TRIP);
        tick();
        check("cooldown_done", state, S_LOCK);
        cfg_arm = 1'b1;

        // Reset asserted in CONFIRM: straight to DISARMED, no reset pulse.
        reset_req = 1'b1; tick(); reset_req = 1'b0;
        rst = 1'b1; reset_confirm = 1'b1; tick();
        rst = 1'b0; reset_confirm = 1'b0;
        check("rst_mid_state", state, S_DIS);
        check("rst_mid_no_reset", ks_reset, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst           = ($urandom_range(0, 299) == 0);
            cfg_arm       = ($urandom_range(0, 9) != 0);
            trig_src      = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            reset_req     = ($urandom_range(0, 5) == 0);
            reset_confirm = ($urandom_range(0, 5) == 0);
            reset_key     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : cfg_reset_key;
            if ($urandom_range(0, 99) == 0) stuck = ~stuck;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
